// File: rtl/aes_pkg.sv
// Shared AES definitions: data widths, GF(2^8) helpers and the controller state encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Multiply by x in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product built from repeated xtime; constant operands fold away.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// One-column MixColumns transform (forward, or inverse when MIXCOL_INV_EN is defined and mode=1).
// Latency: purely combinational.
// Backpressure: none; output follows input.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] col_in,
    input  logic              mode,
    output logic [WORD_W-1:0] col_out
);

    logic [BYTE_W-1:0] a0, a1, a2, a3;
    logic [BYTE_W-1:0] f0, f1, f2, f3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Forward circulant {02,03,01,01}; 03*a is written as xtime(a)^a.
    always_comb begin
        f0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        f1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        f2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        f3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

`ifdef MIXCOL_INV_EN
    logic [BYTE_W-1:0] i0, i1, i2, i3;

    // Inverse circulant {0e,0b,0d,09}.
    always_comb begin
        i0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        i1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        i2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        i3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

    assign col_out = mode ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
`else
    // Forward-only build: the mode pin is kept for a uniform interface but has no effect.
    logic unused_mode;
    assign unused_mode = mode;
    assign col_out     = {f0, f1, f2, f3};
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one shared column unit steps through columns 0..3; MIXCOL_INV_EN adds inv_in/InvMixColumns.
// Latency: out_valid rises 4 cycles after the accepting edge; one idle cycle between results minimum.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out
`ifdef MIXCOL_INV_EN
    ,
    input  logic               inv_in
`endif
);

    fsm_state_t         state_q;
    logic [1:0]         col_cnt;
    logic [STATE_W-1:0] work;
    logic [WORD_W-1:0]  col_cur;
    logic [WORD_W-1:0]  col_new;
    logic               mode;

`ifdef MIXCOL_INV_EN
    logic inv_q;
    assign mode = inv_q;
`else
    assign mode = 1'b0;
`endif

    // Pick the column currently being transformed out of the working register.
    always_comb begin
        col_cur = work[127:96];
        case (col_cnt)
            2'd0:    col_cur = work[127:96];
            2'd1:    col_cur = work[95:64];
            2'd2:    col_cur = work[63:32];
            default: col_cur = work[31:0];
        endcase
    end

    mix_column_word u_col (
        .col_in  (col_cur),
        .mode    (mode),
        .col_out (col_new)
    );

    // Controller: accept in IDLE, rewrite one column per BUSY cycle in place, hold the result in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_cnt <= 2'd0;
            work    <= '0;
`ifdef MIXCOL_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work    <= state_in;
                        col_cnt <= 2'd0;
                        state_q <= ST_BUSY;
`ifdef MIXCOL_INV_EN
                        inv_q   <= inv_in;
`endif
                    end
                end
                ST_BUSY: begin
                    case (col_cnt)
                        2'd0:    work[127:96] <= col_new;
                        2'd1:    work[95:64]  <= col_new;
                        2'd2:    work[63:32]  <= col_new;
                        default: work[31:0]   <= col_new;
                    endcase
                    // The counter parks at 3 rather than wrapping; the last column ends the pass.
                    if (col_cnt == 2'd3) begin
                        state_q <= ST_DONE;
                    end else begin
                        col_cnt <= col_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign state_out = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a matrix-product reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef MIXCOL_INV_EN
    logic         inv_in;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
`ifdef MIXCOL_INV_EN
        ,
        .inv_in    (inv_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain shift-and-add GF(2^8) product modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h11b;
        end
        return p[7:0];
    endfunction

    // out[r][c] = sum_k M[r][k] * s[k][c], M circulant with first row base.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0]   base [4];
        logic [127:0] res;
        logic [7:0]   acc;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(base[(k - r + 4) % 4], s[127 - 8*(4*c + k) -: 8]);
                res[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Drives one transaction from an idle negedge; returns result and edges from accept to out_valid.
    task automatic run_op(input logic [127:0] s, input bit inv,
                          output logic [127:0] res, output int lat);
        state_in = s;
        in_valid = 1'b1;
`ifdef MIXCOL_INV_EN
        inv_in   = inv;
`else
        if (inv) $display("note: inverse request ignored in forward-only build");
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        state_in = ~s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = state_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++;
        if (state_out !== 128'h0) begin n_bad++; $display("FAIL reset_state_out got=%h want=0", state_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward_vector;
        logic [127:0] res;
        int lat;
        run_op(128'h4773b91ff72f354361cb018ea1e6cf2c, 1'b0, res, lat);
        n_cmp++;
        if (res !== 128'hbd6e7c3df2b5779e0b61216e8b10b689) begin
            n_bad++; $display("FAIL fwd_vector got=%h want=bd6e7c3df2b5779e0b61216e8b10b689", res);
        end
        n_cmp++;
        if (res !== ref_mix(128'h4773b91ff72f354361cb018ea1e6cf2c, 1'b0)) begin
            n_bad++; $display("FAIL fwd_vector_model got=%h want=%h", res, ref_mix(128'h4773b91ff72f354361cb018ea1e6cf2c, 1'b0));
        end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL fwd_latency got=%0d want=4", lat); end
    endtask

    task automatic test_fips_column;
        logic [127:0] res;
        int lat;
        run_op({32'hd4bf5d30, 96'h0}, 1'b0, res, lat);
        n_cmp++;
        if (res !== {32'h046681e5, 96'h0}) begin
            n_bad++; $display("FAIL fips_column got=%h want=%h", res, {32'h046681e5, 96'h0});
        end
    endtask

`ifdef MIXCOL_INV_EN
    task automatic test_inverse;
        logic [127:0] res;
        int lat;
        run_op(128'hfde3bad205e5d0d73547964ef1fe37f1, 1'b1, res, lat);
        n_cmp++;
        if (res !== 128'h2d7e86a339d9393ee6570a1101904e16) begin
            n_bad++; $display("FAIL inv_vector got=%h want=2d7e86a339d9393ee6570a1101904e16", res);
        end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL inv_latency got=%0d want=4", lat); end
    endtask
`endif

    task automatic test_random;
        logic [127:0] s;
        logic [127:0] res;
        bit inv;
        int lat;
        for (int n = 0; n < 16; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_INV_EN
            inv = bit'($urandom_range(0, 1));
`else
            inv = 1'b0;
`endif
            run_op(s, inv, res, lat);
            n_cmp++;
            if (res !== ref_mix(s, inv)) begin
                n_bad++; $display("FAIL random[%0d] in=%h inv=%0d got=%h want=%h", n, s, inv, res, ref_mix(s, inv));
            end
            n_cmp++;
            if (lat !== 4) begin n_bad++; $display("FAIL random_latency[%0d] got=%0d want=4", n, lat); end
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] s;
        logic [127:0] held;
        int wait_cnt;
        s = {$urandom, $urandom, $urandom, $urandom};
        state_in = s;
        in_valid = 1'b1;
`ifdef MIXCOL_INV_EN
        inv_in   = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        held = state_out;
        n_cmp++;
        if (held !== ref_mix(s, 1'b0)) begin n_bad++; $display("FAIL bp_result got=%h want=%h", held, ref_mix(s, 1'b0)); end
        // Offer a second state while the result sits unconsumed.
        state_in = ~s;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
            n_cmp++;
            if (state_out !== held) begin n_bad++; $display("FAIL bp_stable[%0d] got=%h want=%h", i, state_out, held); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (state_out !== held) begin n_bad++; $display("FAIL bp_ignored_input got=%h want=%h", state_out, held); end
    endtask

    task automatic test_reset_mid;
        int seen;
        state_in = {$urandom | 32'h1, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        n_cmp++;
        if (state_out !== 128'h0) begin n_bad++; $display("FAIL midrst_state_out got=%h want=0", state_out); end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_result got=%0d want=0", seen); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] vec;
        logic [127:0] want;
        int stamps [3];
        int found;
        bit inv;
        vec = 128'hd1876c0f79c4300ab45594add66ff41f;
`ifdef MIXCOL_INV_EN
        inv    = 1'b1;
        inv_in = 1'b1;
`else
        inv = 1'b0;
`endif
        want = ref_mix(vec, inv);
        state_in  = vec;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 40 && found < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                stamps[found] = cyc;
                found++;
                n_cmp++;
                if (state_out !== want) begin n_bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", found, state_out, want); end
`ifdef MIXCOL_INV_EN
                n_cmp++;
                if (state_out !== 128'h39daee38f4f1a82aaf432410c36d45b9) begin
                    n_bad++; $display("FAIL b2b_inv_vector got=%h want=39daee38f4f1a82aaf432410c36d45b9", state_out);
                end
`endif
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (found !== 3) begin
            n_bad++; $display("FAIL b2b_count got=%0d want=3", found);
        end else begin
            n_cmp++;
            if (stamps[1] - stamps[0] !== 6) begin n_bad++; $display("FAIL b2b_spacing0 got=%0d want=6", stamps[1] - stamps[0]); end
            n_cmp++;
            if (stamps[2] - stamps[1] !== 6) begin n_bad++; $display("FAIL b2b_spacing1 got=%0d want=6", stamps[2] - stamps[1]); end
        end
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
`ifdef MIXCOL_INV_EN
        inv_in    = 1'b0;
`endif
        @(negedge clk);
        test_reset;
        test_forward_vector;
        test_fips_column;
`ifdef MIXCOL_INV_EN
        test_inverse;
`endif
        test_random;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
